striping_scheduler: RTL and testbench

//   Sequences the two-lane striping demux in front of the lane FIFOs. Drives the demux

---
 rtl/striping_scheduler_if.sv | 30 +++
 rtl/striping_scheduler.sv | 121 ++++++++++++
 tb/tb_striping_scheduler.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/striping_scheduler_if.sv
// Purpose: upstream/demux handshake bundle for the two-lane striping scheduler.
// Signals:
//   enable, valid_in, data_in     upstream control and word (master drives)
//   lane0_afull, lane1_afull      lane FIFO almost-full flags (master drives)
//   ready_out, selector, data_out,
//   valid_out_0, valid_out_1      scheduler outputs (slave drives)
interface striping_scheduler_if #(
  parameter int unsigned DATA_W = 32
);
  logic              enable;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              lane0_afull;
  logic              lane1_afull;
  logic              ready_out;
  logic              selector;
  logic [DATA_W-1:0] data_out;
  logic              valid_out_0;
  logic              valid_out_1;

  modport master (
    output enable, valid_in, data_in, lane0_afull, lane1_afull,
    input  ready_out, selector, data_out, valid_out_0, valid_out_1
  );

  modport slave (
    input  enable, valid_in, data_in, lane0_afull, lane1_afull,
    output ready_out, selector, data_out, valid_out_0, valid_out_1
  );
endinterface

// File: rtl/striping_scheduler.sv
// Purpose: sequences the two-lane striping demux. Bursts of BURST_LEN accepted
//   words alternate lane0/lane1 in strict order; the target lane's almost-full
//   flag backpressures upstream instead of skipping to the other lane.
// Ports:
//   clk_f      clock, rising edge
//   reset_L    asynchronous active-low reset
//   bus        striping_scheduler_if.slave (handshake, data and demux controls)
//   word_cnt   accepted-word counter (stats)
//   stall_cnt  cycles with valid_in high, ready_out low and scheduler active
// Configuration:
//   STRIPING_STATS_EN  defined: statistics counters are built.
//                      undefined: word_cnt and stall_cnt are tied to 0.
module striping_scheduler #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk_f,
  input  logic                 reset_L,
  striping_scheduler_if.slave  bus,
  output logic [CNT_W-1:0]     word_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e            state_q;
  logic              selector_q;
  logic              selector_d;
  logic [BEAT_W-1:0] beat_cnt_q;
  logic [BEAT_W-1:0] beat_cnt_d;
  logic              target_afull;
  logic              ready;
  logic              accept;
  logic              burst_done;

  // Backpressure only looks at the lane currently selected.
  assign target_afull = selector_q ? bus.lane1_afull : bus.lane0_afull;
  assign ready        = (state_q != ST_IDLE) & ~target_afull;
  assign accept       = bus.valid_in & ready;
  assign burst_done   = accept & (beat_cnt_q == BEAT_LAST);

  assign bus.ready_out   = ready;
  assign bus.selector    = selector_q;
  assign bus.data_out    = bus.data_in;
  assign bus.valid_out_0 = accept & ~selector_q;
  assign bus.valid_out_1 = accept & selector_q;

  // Beat counter and lane select advance only on accepted words.
  always_comb begin
    selector_d = selector_q;
    beat_cnt_d = beat_cnt_q;
    if (burst_done) begin
      selector_d = ~selector_q;
      beat_cnt_d = '0;
    end else if (accept) begin
      beat_cnt_d = beat_cnt_q + BEAT_W'(1);
    end
  end

  // Scheduler FSM plus lane/beat registers.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_IDLE;
      selector_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      selector_q <= selector_d;
      beat_cnt_q <= beat_cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (bus.enable) state_q <= ST_RUN;
        end
        ST_RUN: begin
          // A burst completing on the same edge enable falls needs no drain.
          if (!bus.enable) begin
            if ((beat_cnt_q == '0) || burst_done) state_q <= ST_IDLE;
            else                                  state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (burst_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef STRIPING_STATS_EN
  logic [CNT_W-1:0] word_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             stall;

  assign stall = bus.valid_in & ~ready & (state_q != ST_IDLE);

  // Free-running statistics, wrapping silently.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept) word_cnt_q  <= word_cnt_q + CNT_W'(1);
      if (stall)  stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign word_cnt  = word_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign word_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_striping_scheduler.sv
// Purpose: directed self-checking bench for striping_scheduler. One instance
//   with BURST_LEN=1 and one with BURST_LEN=4 share clock and reset.
module tb_striping_scheduler;

`ifdef STRIPING_STATS_EN
  localparam int unsigned STATS = 1;
`else
  localparam int unsigned STATS = 0;
`endif

  logic        clk_f;
  logic        reset_L;
  logic [15:0] word_cnt1, stall_cnt1, word_cnt4, stall_cnt4;
  int          errors = 0;
  int          checks = 0;

  striping_scheduler_if #(.DATA_W(32)) u_if1 ();
  striping_scheduler_if #(.DATA_W(32)) u_if4 ();

  striping_scheduler #(.DATA_W(32), .BURST_LEN(1), .CNT_W(16)) u_dut1 (
    .clk_f(clk_f), .reset_L(reset_L), .bus(u_if1),
    .word_cnt(word_cnt1), .stall_cnt(stall_cnt1)
  );

  striping_scheduler #(.DATA_W(32), .BURST_LEN(4), .CNT_W(16)) u_dut4 (
    .clk_f(clk_f), .reset_L(reset_L), .bus(u_if4),
    .word_cnt(word_cnt4), .stall_cnt(stall_cnt4)
  );

  initial begin
    clk_f = 1'b0;
    forever #5 clk_f = ~clk_f;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Drive one cycle on the BURST_LEN=1 instance, settle, return mid-low phase.
  task automatic cyc1(input logic en, input logic v, input logic [31:0] d,
                      input logic a0, input logic a1);
    @(negedge clk_f);
    u_if1.enable = en; u_if1.valid_in = v; u_if1.data_in = d;
    u_if1.lane0_afull = a0; u_if1.lane1_afull = a1;
    #1;
  endtask

  task automatic cyc4(input logic en, input logic v, input logic [31:0] d,
                      input logic a0, input logic a1);
    @(negedge clk_f);
    u_if4.enable = en; u_if4.valid_in = v; u_if4.data_in = d;
    u_if4.lane0_afull = a0; u_if4.lane1_afull = a1;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_f);
    reset_L = 1'b0;
    u_if1.enable = 0; u_if1.valid_in = 0; u_if1.data_in = '0;
    u_if1.lane0_afull = 0; u_if1.lane1_afull = 0;
    u_if4.enable = 0; u_if4.valid_in = 0; u_if4.data_in = '0;
    u_if4.lane0_afull = 0; u_if4.lane1_afull = 0;
    @(negedge clk_f);
    @(negedge clk_f);
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_f);
    reset_L = 1'b0;
    u_if1.enable = 1; u_if1.valid_in = 1; u_if1.data_in = 32'h1;
    u_if1.lane0_afull = 0; u_if1.lane1_afull = 0;
    u_if4.enable = 1; u_if4.valid_in = 1; u_if4.data_in = 32'h2;
    u_if4.lane0_afull = 0; u_if4.lane1_afull = 0;
    @(posedge clk_f);
    #1;
    checks++;
    if ({u_if1.ready_out, u_if1.valid_out_1, u_if1.valid_out_0, u_if1.selector} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs1 got=%b exp=0000",
               {u_if1.ready_out, u_if1.valid_out_1, u_if1.valid_out_0, u_if1.selector});
    end
    checks++;
    if ({u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0, u_if4.selector} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs4 got=%b exp=0000",
               {u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0, u_if4.selector});
    end
    checks++;
    if ({word_cnt1, stall_cnt1, word_cnt4, stall_cnt4} !== 64'h0) begin
      errors++;
      $display("FAIL reset_cnts got=%h exp=0", {word_cnt1, stall_cnt1, word_cnt4, stall_cnt4});
    end
    do_reset();
  endtask

  // BURST_LEN=1: strict per-word alternation with data forwarded unchanged.
  task automatic test_alternate();
    logic [31:0] d;
    logic        odd;
    do_reset();
    cyc1(1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      d   = 32'hA0 + 32'(i);
      odd = (i % 2) == 1;
      cyc1(1, 1, d, 0, 0);
      checks++;
      if ({u_if1.valid_out_1, u_if1.valid_out_0, u_if1.selector} !== {odd, ~odd, odd}) begin
        errors++;
        $display("FAIL alt_lane[%0d] got=%b exp=%b", i,
                 {u_if1.valid_out_1, u_if1.valid_out_0, u_if1.selector}, {odd, ~odd, odd});
      end
      checks++;
      if (u_if1.data_out !== d) begin
        errors++;
        $display("FAIL alt_data[%0d] got=%h exp=%h", i, u_if1.data_out, d);
      end
    end
    cyc1(1, 0, 32'h0, 0, 0);
    checks++;
    if ({u_if1.selector, word_cnt1} !== {1'b0, 16'(STATS * 6)}) begin
      errors++;
      $display("FAIL alt_cnt got=%b/%0d exp=0/%0d", u_if1.selector, word_cnt1, STATS * 6);
    end
    checks++;
    if (stall_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL alt_stall got=%0d exp=0", stall_cnt1);
    end
  endtask

  // BURST_LEN=4: words 0-3 on lane0, 4-7 on lane1.
  task automatic test_burst4();
    logic hi;
    do_reset();
    cyc4(1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      hi = (i >= 4);
      cyc4(1, 1, 32'(i), 0, 0);
      checks++;
      if ({u_if4.valid_out_1, u_if4.valid_out_0, u_if4.selector} !== {hi, ~hi, hi}) begin
        errors++;
        $display("FAIL burst_lane[%0d] got=%b exp=%b", i,
                 {u_if4.valid_out_1, u_if4.valid_out_0, u_if4.selector}, {hi, ~hi, hi});
      end
    end
    cyc4(1, 0, 32'h0, 0, 0);
    checks++;
    if ({u_if4.selector, word_cnt4} !== {1'b0, 16'(STATS * 8)}) begin
      errors++;
      $display("FAIL burst_end got=%b/%0d exp=0/%0d", u_if4.selector, word_cnt4, STATS * 8);
    end
  endtask

  // Target lane almost full: stall, no skip; other lane's flag ignored.
  task automatic test_afull();
    do_reset();
    cyc4(1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc4(1, 1, 32'h55, 1, 0);
      checks++;
      if ({u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0} !== 3'b000) begin
        errors++;
        $display("FAIL afull_stall[%0d] got=%b exp=000", i,
                 {u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0});
      end
    end
    cyc4(1, 1, 32'h55, 0, 1);
    checks++;
    if ({u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0} !== 3'b101) begin
      errors++;
      $display("FAIL afull_resume got=%b exp=101",
               {u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0});
    end
    cyc4(1, 0, 32'h0, 0, 0);
    checks++;
    if ({stall_cnt4, word_cnt4} !== {16'(STATS * 3), 16'(STATS)}) begin
      errors++;
      $display("FAIL afull_cnts got=%0d/%0d exp=%0d/%0d", stall_cnt4, word_cnt4,
               STATS * 3, STATS);
    end
  endtask

  // Enable drops mid-burst: drain on same lane, idle, resume on lane1.
  task automatic test_drain();
    do_reset();
    cyc4(1, 0, 32'h0, 0, 0);
    cyc4(1, 1, 32'h10, 0, 0);
    cyc4(1, 1, 32'h11, 0, 0);
    cyc4(0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc4(0, 1, 32'h12 + 32'(i), 0, 0);
      checks++;
      if ({u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0} !== 3'b101) begin
        errors++;
        $display("FAIL drain_word[%0d] got=%b exp=101", i,
                 {u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0});
      end
    end
    cyc4(0, 1, 32'h20, 0, 0);
    checks++;
    if ({u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0, u_if4.selector} !== 4'b0001) begin
      errors++;
      $display("FAIL drain_idle got=%b exp=0001",
               {u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0, u_if4.selector});
    end
    cyc4(1, 0, 32'h0, 0, 0);
    cyc4(1, 1, 32'h21, 0, 0);
    checks++;
    if ({u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0} !== 3'b110) begin
      errors++;
      $display("FAIL drain_reenable got=%b exp=110",
               {u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0});
    end
  endtask

  // Enable falls on the burst-completing accept: toggle lane and go idle.
  task automatic test_enable_fall_on_last();
    do_reset();
    cyc4(1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) cyc4(1, 1, 32'(i), 0, 0);
    cyc4(0, 1, 32'h3, 0, 0);
    checks++;
    if ({u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0} !== 3'b101) begin
      errors++;
      $display("FAIL fall_last_accept got=%b exp=101",
               {u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0});
    end
    cyc4(0, 1, 32'h4, 0, 0);
    checks++;
    if ({u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0, u_if4.selector} !== 4'b0001) begin
      errors++;
      $display("FAIL fall_last_idle got=%b exp=0001",
               {u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0, u_if4.selector});
    end
  endtask

  // Asynchronous reset in the middle of a lane1 burst.
  task automatic test_reset_mid_burst();
    do_reset();
    cyc4(1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 5; i++) cyc4(1, 1, 32'(i), 0, 0);
    cyc4(1, 1, 32'h5, 0, 0);
    checks++;
    if ({u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0, u_if4.selector} !== 4'b1101) begin
      errors++;
      $display("FAIL mid_pre got=%b exp=1101",
               {u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0, u_if4.selector});
    end
    #1;
    reset_L = 1'b0;
    #1;
    checks++;
    if ({u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0, u_if4.selector, word_cnt4} !==
        {4'b0000, 16'd0}) begin
      errors++;
      $display("FAIL mid_async got=%b/%0d exp=0000/0",
               {u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0, u_if4.selector}, word_cnt4);
    end
    cyc4(1, 0, 32'h0, 0, 0);
    reset_L = 1'b1;
    cyc4(1, 1, 32'h77, 0, 0);
    checks++;
    if ({u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0} !== 3'b101) begin
      errors++;
      $display("FAIL mid_restart got=%b exp=101",
               {u_if4.ready_out, u_if4.valid_out_1, u_if4.valid_out_0});
    end
  endtask

  initial begin
    reset_L = 1'b0;
    test_reset();
    test_alternate();
    test_burst4();
    test_afull();
    test_drain();
    test_enable_fall_on_last();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
